// File: rtl/sum_series_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum_series_pkg
// Description : Shared state encoding and default widths for the series
//               scheduler and its datapath core.
// Revision    : 1.0 - initial release
// ============================================================================
package sum_series_pkg;

    localparam int c_DEF_NREQ = 4;
    localparam int c_DEF_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sum_series_core.sv
`default_nettype none
// ============================================================================
// Module      : sum_series_core
// Description : Counter / accumulator datapath computing 1+2+...+N, with the
//               captured operand register and the C==Nq comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_series_core
    import sum_series_pkg::*;
#(
    parameter int W = c_DEF_W
) (
    input  logic           Clk,
    input  logic           RstN,
    input  logic           Load,
    input  logic           Step,
    input  logic [W-1:0]   Nin,
    output logic           Eq,
    output logic [2*W-1:0] R
);

    logic [W-1:0]   r_nq;
    logic [W-1:0]   r_c;
    logic [2*W-1:0] r_r;

    // Load captures the operand and clears the datapath together, so both
    // C and R already read zero while the scheduler sits in LOAD.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_nq <= '0;
            r_c  <= '0;
            r_r  <= '0;
        end else if (Load) begin
            r_nq <= Nin;
            r_c  <= '0;
            r_r  <= '0;
        end else if (Step) begin
            r_c  <= r_c + W'(1);
            r_r  <= r_r + {{W{1'b0}}, r_c} + (2*W)'(1);
        end
    end

    assign Eq = (r_c == r_nq);
    assign R  = r_r;

endmodule
`default_nettype wire

// File: rtl/sum_series_sched.sv
`default_nettype none
// ============================================================================
// Module      : sum_series_sched
// Description : Round-robin scheduler sharing one sum-of-series core between
//               NREQ requesters; returns N(N+1)/2 tagged with requester id.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_series_sched
    import sum_series_pkg::*;
#(
    parameter  int NREQ = c_DEF_NREQ,
    parameter  int W    = c_DEF_W,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic [NREQ-1:0]   Req,
    input  logic [NREQ*W-1:0] N_in,
    output logic [NREQ-1:0]   Gnt,
    output logic              Busy,
    output logic              Done,
    output logic [ID_W-1:0]   DoneId,
    output logic [2*W-1:0]    Sum
);

    state_t            r_state;
    logic [ID_W-1:0]   r_last;
    logic [ID_W-1:0]   r_id;

    logic              w_found;
    logic [ID_W-1:0]   w_win;
    logic [W-1:0]      w_nin;
    logic              w_load;
    logic              w_step;
    logic              w_eq;
    logic [2*W-1:0]    w_r;
    logic [W-1:0]      w_ops [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_operand
        assign w_ops[gi] = N_in[gi*W +: W];
    end

    // Search begins one past the last winner and wraps, so every pending
    // requester is reached within NREQ grants.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(r_last) + k) % NREQ;
            if (!w_found && Req[idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(idx);
            end
        end
    end

    assign w_nin  = w_ops[w_win];
    assign w_load = (r_state == ST_IDLE) && w_found;
    assign w_step = (r_state == ST_RUN) && !w_eq;

    sum_series_core #(
        .W (W)
    ) u_core (
        .Clk  (Clk),
        .RstN (RstN),
        .Load (w_load),
        .Step (w_step),
        .Nin  (w_nin),
        .Eq   (w_eq),
        .R    (w_r)
    );

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_state <= ST_IDLE;
            r_last  <= ID_W'(NREQ - 1);
            r_id    <= '0;
            Gnt     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            DoneId  <= '0;
            Sum     <= '0;
        end else begin
            Gnt  <= '0;
            Done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_LOAD;
                        r_id    <= w_win;
                        r_last  <= w_win;
                        Gnt     <= NREQ'(1) << w_win;
                        Busy    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_eq) begin
                        r_state <= ST_DONE;
                        Done    <= 1'b1;
                        Sum     <= w_r;
                        DoneId  <= r_id;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    Busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sum_series_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_series_sched
// Description : Self-checking bench for sum_series_sched (vectors + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_series_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int ID_W = 2;

    logic              Clk;
    logic              RstN;
    logic [NREQ-1:0]   Req;
    logic [NREQ*W-1:0] N_in;
    logic [NREQ-1:0]   Gnt;
    logic              Busy;
    logic              Done;
    logic [ID_W-1:0]   DoneId;
    logic [2*W-1:0]    Sum;

    int checks;
    int failures;

    typedef struct {
        int id;
        int n;
        int sum;
    } vec_t;

    vec_t vecs [7];

    sum_series_sched #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .Clk    (Clk),
        .RstN   (RstN),
        .Req    (Req),
        .N_in   (N_in),
        .Gnt    (Gnt),
        .Busy   (Busy),
        .Done   (Done),
        .DoneId (DoneId),
        .Sum    (Sum)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Returns number of negedges waited; fails on timeout.
    task automatic wait_gnt(input string name, output int cyc);
        cyc = 0;
        while (Gnt == '0 && cyc < 40) begin
            @(negedge Clk);
            cyc++;
        end
        if (Gnt == '0) chk({name, "_gnt_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (!Done && cyc < 400) begin
            @(negedge Clk);
            cyc++;
        end
        if (!Done) chk({name, "_done_timeout"}, 0, 1);
    endtask

    function automatic int gnt_id(input logic [NREQ-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic run_job(input string name, input int id, input int n, input int exp_sum);
        int cyc;
        N_in[id*W +: W] = W'(n);
        Req[id] = 1'b1;
        wait_gnt(name, cyc);
        chk({name, "_gnt"}, longint'(Gnt), longint'(1 << id));
        chk({name, "_busy"}, longint'(Busy), 1);
        Req[id] = 1'b0;
        @(negedge Clk);
        chk({name, "_gnt_pulse"}, longint'(Gnt), 0);
        cyc = 1;
        while (!Done && cyc < 400) begin
            @(negedge Clk);
            cyc++;
        end
        chk({name, "_latency"}, cyc, n + 2);
        chk({name, "_sum"}, longint'(Sum), exp_sum);
        chk({name, "_id"}, longint'(DoneId), id);
        @(negedge Clk);
        chk({name, "_done_pulse"}, longint'(Done), 0);
        chk({name, "_sum_held"}, longint'(Sum), exp_sum);
    endtask

    initial begin
        int cyc;
        int exp_order [4];
        bit saw;

        checks   = 0;
        failures = 0;
        RstN     = 1'b0;
        Req      = '0;
        N_in     = '0;

        vecs[0] = '{0, 5, 15};
        vecs[1] = '{2, 0, 0};
        vecs[2] = '{3, 255, 32640};
        vecs[3] = '{1, 7, 28};
        vecs[4] = '{0, 1, 1};
        vecs[5] = '{2, 100, 5050};
        vecs[6] = '{1, 200, 20100};

        @(negedge Clk);
        @(negedge Clk);
        chk("reset_outputs", longint'({Gnt, Busy, Done, DoneId, Sum}), 0);
        RstN = 1'b1;
        @(negedge Clk);

        // All four requesting: grants 0,1,2,3, next Gnt 2 cycles after Done
        N_in = {8'd4, 8'd3, 8'd2, 8'd1};
        Req  = 4'b1111;
        wait_gnt("all4", cyc);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("all4_gnt%0d", j), gnt_id(Gnt), j);
            Req[j] = 1'b0;
            wait_done("all4", cyc);
            chk($sformatf("all4_sum%0d", j), longint'(Sum), (j + 1) * (j + 2) / 2);
            chk($sformatf("all4_id%0d", j), longint'(DoneId), j);
            if (j < 3) begin
                cyc = 0;
                while (Gnt == '0 && cyc < 20) begin
                    @(negedge Clk);
                    cyc++;
                end
                chk($sformatf("all4_gap%0d", j), cyc, 2);
            end
        end
        @(negedge Clk);

        // Fairness: requesters 0 and 2 held continuously
        exp_order = '{0, 2, 0, 2};
        N_in = '0;
        N_in[0*W +: W] = 8'd2;
        N_in[2*W +: W] = 8'd3;
        Req  = 4'b0101;
        for (int j = 0; j < 4; j++) begin
            wait_gnt("fair", cyc);
            chk($sformatf("fair_gnt%0d", j), gnt_id(Gnt), exp_order[j]);
            if (j == 3) Req = '0;
            wait_done("fair", cyc);
            chk($sformatf("fair_sum%0d", j), longint'(Sum), (exp_order[j] == 0) ? 3 : 6);
            @(negedge Clk);
        end
        @(negedge Clk);

        for (int v = 0; v < 7; v++) begin
            run_job($sformatf("vec%0d", v), vecs[v].id, vecs[v].n, vecs[v].sum);
        end

        // Req[3] pulsed only while busy must never be granted
        N_in[1*W +: W] = 8'd6;
        Req[1] = 1'b1;
        wait_gnt("busy", cyc);
        Req[1] = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        N_in[3*W +: W] = 8'd9;
        Req[3] = 1'b1;
        @(negedge Clk);
        Req[3] = 1'b0;
        wait_done("busy", cyc);
        chk("busy_sum", longint'(Sum), 21);
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (Gnt != '0) saw = 1'b1;
        end
        chk("busy_ignored", longint'(saw), 0);

        // Reset in the middle of RUN aborts the job
        N_in[0*W +: W] = 8'd10;
        Req[0] = 1'b1;
        wait_gnt("rst", cyc);
        Req[0] = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_pre_busy", longint'(Busy), 1);
        RstN = 1'b0;
        #1;
        chk("rst_outputs", longint'({Gnt, Busy, Done, DoneId, Sum}), 0);
        @(negedge Clk);
        @(negedge Clk);
        RstN = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge Clk);
            if (Done || Busy) saw = 1'b1;
        end
        chk("rst_no_done", longint'(saw), 0);
        run_job("rst_rerun", 1, 3, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=1 required=0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
